// File: rtl/tcam_conf_master.sv
// tcam_conf_master: cData control initiator. Turns host register requests into 2-word cData
//   command packets, matches the read response and returns its 64-bit payload to the host.
// Latency: head on the cycle after accept, tail after the head transfer; resp_valid one cycle
//   after the last relevant event (our tail for writes, response tail for reads, or timeout).
// Backpressure: req_ready is high only in IDLE; outgoing words are held stable while
//   cdata_out_ready is low; incoming words are always accepted (cdata_in_ready tied high).
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   req_valid/req_ready           host request handshake; req_wr, req_lmid, req_entry, req_idx,
//                                 req_wdata are latched on accept
//   resp_valid/rdata/timeout      one-cycle completion pulse; rdata held until the next pulse
//   cdata_out_wr/out/out_ready    outgoing cData words (transfer when wr && ready)
//   cdata_in_wr/in/in_ready       incoming cData words
//   drop_cnt                      saturating count of incoming packets that were not our response
module tcam_conf_master #(
    parameter logic [7:0] SRC_ID      = 8'h01,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [7:0]   req_lmid,
    input  logic [2:0]   req_entry,
    input  logic [3:0]   req_idx,
    input  logic [63:0]  req_wdata,
    output logic         resp_valid,
    output logic [63:0]  resp_rdata,
    output logic         resp_timeout,
    output logic         cdata_out_wr,
    output logic [133:0] cdata_out,
    input  logic         cdata_out_ready,
    input  logic         cdata_in_wr,
    input  logic [133:0] cdata_in,
    output logic         cdata_in_ready,
    output logic [15:0]  drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HEAD,
        S_SEND_TAIL,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;

    // Latched request
    logic          wr_q;
    logic [7:0]    lmid_q;
    logic [2:0]    entry_q;
    logic [3:0]    idx_q;
    logic [63:0]   wdata_q;
    logic [11:0]   seq_q;       // sequence number for the next request
    logic [11:0]   seq_lat_q;   // sequence number carried by the request in flight

    // Incoming packet tracking
    logic          in_pkt_q;    // inside a packet (head seen, tail not yet)
    logic          in_match_q;  // the open packet is our response
    logic          got_match_q; // a response head was already accepted for this request
    logic          rsp_done_q;  // our response completed before our own tail went out
    logic [63:0]   cap_q;

    logic [15:0]   tmo_q;
    logic [15:0]   drop_cnt_q;
    logic          resp_valid_q;
    logic          resp_timeout_q;
    logic [63:0]   resp_rdata_q;

    logic          in_head;
    logic          in_tail;
    logic          match_window;
    logic          hdr_match;
    logic          rsp_tail;
    logic          tmo_hit;
    logic          tmo_expire;
    logic          accept;
    logic          unused_in_bits;

    assign in_head      = cdata_in_wr && (cdata_in[133:132] == 2'b01);
    assign in_tail      = cdata_in_wr && (cdata_in[133:132] == 2'b10);
    // Matching already runs while our tail is pending so an early response is not lost.
    assign match_window = (state_q == S_SEND_TAIL) || (state_q == S_WAIT_RESP);
    assign hdr_match    = in_head && match_window && !wr_q && !got_match_q
                          && (cdata_in[126:124] == 3'b011)
                          && (cdata_in[103:96]  == SRC_ID)
                          && (cdata_in[111:104] == lmid_q)
                          && (cdata_in[123:112] == seq_lat_q);
    assign rsp_tail     = in_tail && in_pkt_q && in_match_q;
    // A response in progress (or starting this cycle) suspends the timeout until its tail.
    assign tmo_hit      = (tmo_q == TMO_LAST) && !in_match_q && !hdr_match;
    assign tmo_expire   = (state_q == S_WAIT_RESP) && tmo_hit;
    assign accept       = (state_q == S_IDLE) && req_valid;

    assign unused_in_bits = ^{cdata_in[131:127], cdata_in[95:64]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_SEND_HEAD;
                end
            end
            S_SEND_HEAD: begin
                if (cdata_out_ready) begin
                    state_d = S_SEND_TAIL;
                end
            end
            S_SEND_TAIL: begin
                if (cdata_out_ready) begin
                    if (wr_q || rsp_done_q || rsp_tail) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (rsp_tail || tmo_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q           <= 1'b0;
            lmid_q         <= '0;
            entry_q        <= '0;
            idx_q          <= '0;
            wdata_q        <= '0;
            seq_q          <= '0;
            seq_lat_q      <= '0;
            in_pkt_q       <= 1'b0;
            in_match_q     <= 1'b0;
            got_match_q    <= 1'b0;
            rsp_done_q     <= 1'b0;
            cap_q          <= '0;
            tmo_q          <= '0;
            drop_cnt_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_rdata_q   <= '0;
        end else begin
            if (accept) begin
                wr_q        <= req_wr;
                lmid_q      <= req_lmid;
                entry_q     <= req_entry;
                idx_q       <= req_idx;
                wdata_q     <= req_wdata;
                seq_lat_q   <= seq_q;
                seq_q       <= seq_q + 12'd1;
                got_match_q <= 1'b0;
                rsp_done_q  <= 1'b0;
            end

            // Every head opens a packet; only our response is kept, all others are counted.
            if (in_head) begin
                in_pkt_q   <= 1'b1;
                in_match_q <= hdr_match;
                if (hdr_match) begin
                    got_match_q <= 1'b1;
                    cap_q       <= cdata_in[63:0];
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end else if (in_tail && in_pkt_q) begin
                in_pkt_q   <= 1'b0;
                in_match_q <= 1'b0;
                if (in_match_q) begin
                    rsp_done_q <= 1'b1;
                end
            end

            // Zero outside WAIT_RESP, so it always starts from 0 on entry.
            if (state_q != S_WAIT_RESP) begin
                tmo_q <= '0;
            end else if (!(in_match_q || hdr_match)) begin
                tmo_q <= tmo_q + 16'd1;
            end

            resp_valid_q   <= (state_d == S_DONE);
            resp_timeout_q <= (state_d == S_DONE) && tmo_expire;
            if (state_d == S_DONE) begin
                resp_rdata_q <= (wr_q || tmo_expire) ? 64'd0 : cap_q;
            end
        end
    end

    always_comb begin
        cdata_out_wr = 1'b0;
        cdata_out    = '0;
        case (state_q)
            S_SEND_HEAD: begin
                cdata_out_wr = 1'b1;
                cdata_out    = {2'b01, 5'b0, (wr_q ? 3'b010 : 3'b001), seq_lat_q, SRC_ID,
                                lmid_q, 21'b0, entry_q, 4'b0, idx_q,
                                (wr_q ? wdata_q : 64'd0)};
            end
            S_SEND_TAIL: begin
                cdata_out_wr = 1'b1;
                cdata_out    = {2'b10, 132'b0};
            end
            default: begin
                cdata_out_wr = 1'b0;
            end
        endcase
    end

    assign req_ready      = (state_q == S_IDLE);
    assign cdata_in_ready = 1'b1;
    assign resp_valid     = resp_valid_q;
    assign resp_timeout   = resp_timeout_q;
    assign resp_rdata     = resp_rdata_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
